// File: rtl/msrv32_trap_ctrl_if.sv
// Decoder/CSR-side signal bundle of the machine-mode trap controller.
// master = decoder/CSR side driving the controller, slave = the controller itself.
interface msrv32_trap_ctrl_if #(parameter int CAUSE_W = 4);
  logic [4:0]         opcode_6_2_in;
  logic [2:0]         funct3_in;
  logic [11:0]        funct12_in;
  logic               illegal_instr_in;
  logic               misaligned_instr_in;
  logic               misaligned_load_in;
  logic               misaligned_store_in;
  logic               mie_in;
  logic               meie_in, mtie_in, msie_in;
  logic               e_irq_in, t_irq_in, s_irq_in;
  logic               trap_taken_out;
  logic               i_or_e_out;
  logic [CAUSE_W-1:0] cause_out;
  logic               set_cause_out, set_epc_out;
  logic               mie_clear_out, mie_set_out;
  logic               instret_inc_out;
  logic               flush_out;
  logic [1:0]         pc_src_out;

  modport master (
    output opcode_6_2_in, funct3_in, funct12_in, illegal_instr_in, misaligned_instr_in,
           misaligned_load_in, misaligned_store_in, mie_in, meie_in, mtie_in, msie_in,
           e_irq_in, t_irq_in, s_irq_in,
    input  trap_taken_out, i_or_e_out, cause_out, set_cause_out, set_epc_out,
           mie_clear_out, mie_set_out, instret_inc_out, flush_out, pc_src_out
  );

  modport slave (
    input  opcode_6_2_in, funct3_in, funct12_in, illegal_instr_in, misaligned_instr_in,
           misaligned_load_in, misaligned_store_in, mie_in, meie_in, mtie_in, msie_in,
           e_irq_in, t_irq_in, s_irq_in,
    output trap_taken_out, i_or_e_out, cause_out, set_cause_out, set_epc_out,
           mie_clear_out, mie_set_out, instret_inc_out, flush_out, pc_src_out
  );
endinterface

// File: rtl/msrv32_trap_ctrl.sv
// Machine-mode trap/return sequencer: prioritises exceptions and interrupts, drives CSR strobes and PC select.
// Optional MSRV32_WFI_EN adds a WFI sleep state; without it wfi retires as a NOP.
module msrv32_trap_ctrl #(
  parameter int CAUSE_W = 4
) (
  input logic ms_riscv32_mp_clk_in,
  input logic ms_riscv32_mp_rst_n_in,
  msrv32_trap_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    RESET       = 3'd0,
    OPERATING   = 3'd1,
    TRAP_TAKEN  = 3'd2,
    TRAP_RETURN = 3'd3
`ifdef MSRV32_WFI_EN
    , WFI       = 3'd4
`endif
  } state_t;

  state_t             state;
  logic               sys, ecall, ebreak, mret;
  logic               ext_p, sw_p, tm_p, wake, irq, exc, trap;
  logic [CAUSE_W-1:0] nxt_cause;
  logic               nxt_int;
`ifdef MSRV32_WFI_EN
  logic               wfi;
`endif

  always_comb begin
    sys    = (bus.opcode_6_2_in == 5'b11100) && (bus.funct3_in == 3'b000);
    ecall  = sys && (bus.funct12_in == 12'h000);
    ebreak = sys && (bus.funct12_in == 12'h001);
    mret   = sys && (bus.funct12_in == 12'h302);
`ifdef MSRV32_WFI_EN
    wfi    = sys && (bus.funct12_in == 12'h105);
`endif
    ext_p  = bus.meie_in & bus.e_irq_in;
    sw_p   = bus.msie_in & bus.s_irq_in;
    tm_p   = bus.mtie_in & bus.t_irq_in;
    // wake ignores mstatus.MIE so WFI can resume even with interrupts globally off
    wake   = ext_p | sw_p | tm_p;
    irq    = bus.mie_in & wake;
    exc    = bus.misaligned_instr_in | bus.illegal_instr_in | ecall | ebreak |
             bus.misaligned_load_in | bus.misaligned_store_in;
    trap   = exc | irq;

    nxt_int   = 1'b0;
    nxt_cause = '0;
    if      (bus.misaligned_instr_in) nxt_cause = CAUSE_W'(0);
    else if (bus.illegal_instr_in)    nxt_cause = CAUSE_W'(2);
    else if (ebreak)                  nxt_cause = CAUSE_W'(3);
    else if (ecall)                   nxt_cause = CAUSE_W'(11);
    else if (bus.misaligned_load_in)  nxt_cause = CAUSE_W'(4);
    else if (bus.misaligned_store_in) nxt_cause = CAUSE_W'(6);
    else begin
      nxt_int = 1'b1;
      if      (ext_p) nxt_cause = CAUSE_W'(11);
      else if (sw_p)  nxt_cause = CAUSE_W'(3);
      else            nxt_cause = CAUSE_W'(7);
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state          <= RESET;
      bus.i_or_e_out <= 1'b0;
      bus.cause_out  <= '0;
    end else begin
      case (state)
        RESET: state <= OPERATING;
        OPERATING: begin
          if (trap) begin
            bus.cause_out  <= nxt_cause;
            bus.i_or_e_out <= nxt_int;
            state          <= TRAP_TAKEN;
          end else if (mret) begin
            state <= TRAP_RETURN;
`ifdef MSRV32_WFI_EN
          end else if (wfi) begin
            state <= WFI;
`endif
          end
        end
`ifdef MSRV32_WFI_EN
        WFI: begin
          if (wake && bus.mie_in) begin
            bus.cause_out  <= nxt_cause;
            bus.i_or_e_out <= 1'b1;
            state          <= TRAP_TAKEN;
          end else if (wake) begin
            state <= OPERATING;
          end
        end
`endif
        default: state <= OPERATING;
      endcase
    end
  end

  always_comb begin
    bus.trap_taken_out  = 1'b0;
    bus.set_cause_out   = 1'b0;
    bus.set_epc_out     = 1'b0;
    bus.mie_clear_out   = 1'b0;
    bus.mie_set_out     = 1'b0;
    bus.instret_inc_out = 1'b0;
    bus.flush_out       = 1'b0;
    bus.pc_src_out      = 2'b00;
    // gate on the raw reset so nothing strobes while it is held low
    if (ms_riscv32_mp_rst_n_in) begin
      case (state)
        RESET: bus.flush_out = 1'b1;
        OPERATING: begin
          bus.trap_taken_out  = trap;
          bus.instret_inc_out = !trap;
          bus.pc_src_out      = 2'b11;
        end
        TRAP_TAKEN: begin
          bus.set_cause_out = 1'b1;
          bus.set_epc_out   = 1'b1;
          bus.mie_clear_out = 1'b1;
          bus.flush_out     = 1'b1;
          bus.pc_src_out    = 2'b10;
        end
        TRAP_RETURN: begin
          bus.mie_set_out = 1'b1;
          bus.flush_out   = 1'b1;
          bus.pc_src_out  = 2'b01;
        end
`ifdef MSRV32_WFI_EN
        WFI: bus.pc_src_out = 2'b11;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_trap_ctrl.sv
// Directed bench for msrv32_trap_ctrl: reset, cause priority, trap/return sequencing, WFI.
module tb_msrv32_trap_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  msrv32_trap_ctrl_if #(.CAUSE_W(4)) tif ();

  msrv32_trap_ctrl #(.CAUSE_W(4)) dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_n_in(rst_n),
    .bus                   (tif.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    tif.opcode_6_2_in = 5'b01100; tif.funct3_in = 3'b000; tif.funct12_in = 12'h000;
    tif.illegal_instr_in = 0; tif.misaligned_instr_in = 0;
    tif.misaligned_load_in = 0; tif.misaligned_store_in = 0;
    tif.mie_in = 0; tif.meie_in = 0; tif.mtie_in = 0; tif.msie_in = 0;
    tif.e_irq_in = 0; tif.t_irq_in = 0; tif.s_irq_in = 0;
  endtask

  task automatic sys_instr(input logic [11:0] f12);
    tif.opcode_6_2_in = 5'b11100; tif.funct3_in = 3'b000; tif.funct12_in = f12;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if (tif.pc_src_out !== 2'b00) begin failures++; $display("FAIL rst_pc_src got=%b exp=00", tif.pc_src_out); end
    checks++; if ({tif.flush_out, tif.instret_inc_out, tif.trap_taken_out, tif.set_cause_out} !== 4'b0)
      begin failures++; $display("FAIL rst_comb_outs got=%b exp=0000", {tif.flush_out, tif.instret_inc_out, tif.trap_taken_out, tif.set_cause_out}); end
    checks++; if ({tif.i_or_e_out, tif.cause_out} !== 5'd0) begin failures++; $display("FAIL rst_cause got=%0d/%0d exp=0/0", tif.i_or_e_out, tif.cause_out); end
    rst_n = 1;
    @(negedge clk);
    checks++; if ({tif.flush_out, tif.pc_src_out, tif.instret_inc_out} !== 4'b1000)
      begin failures++; $display("FAIL reset_state got=%b exp=1000", {tif.flush_out, tif.pc_src_out, tif.instret_inc_out}); end
    step();
    @(negedge clk);
    checks++; if ({tif.flush_out, tif.pc_src_out, tif.instret_inc_out} !== 4'b0111)
      begin failures++; $display("FAIL operating_entry got=%b exp=0111", {tif.flush_out, tif.pc_src_out, tif.instret_inc_out}); end
    step();
  endtask

  task automatic test_illegal();
    idle(); tif.illegal_instr_in = 1;
    @(negedge clk);
    checks++; if ({tif.trap_taken_out, tif.instret_inc_out} !== 2'b10)
      begin failures++; $display("FAIL illegal_trap got=%b exp=10", {tif.trap_taken_out, tif.instret_inc_out}); end
    step(); idle();
    @(negedge clk);
    checks++; if ({tif.set_cause_out, tif.set_epc_out, tif.mie_clear_out, tif.flush_out, tif.pc_src_out, tif.instret_inc_out, tif.trap_taken_out} !== 8'b1111_1000)
      begin failures++; $display("FAIL illegal_strobes got=%b exp=11111000", {tif.set_cause_out, tif.set_epc_out, tif.mie_clear_out, tif.flush_out, tif.pc_src_out, tif.instret_inc_out, tif.trap_taken_out}); end
    checks++; if ({tif.i_or_e_out, tif.cause_out} !== {1'b0, 4'd2}) begin failures++; $display("FAIL illegal_cause got=%0d/%0d exp=0/2", tif.i_or_e_out, tif.cause_out); end
    step();
    @(negedge clk);
    checks++; if ({tif.set_cause_out, tif.pc_src_out, tif.instret_inc_out} !== 4'b0111)
      begin failures++; $display("FAIL illegal_resume got=%b exp=0111", {tif.set_cause_out, tif.pc_src_out, tif.instret_inc_out}); end
    step();
  endtask

  task automatic test_exc_prio();
    idle(); tif.misaligned_load_in = 1; tif.e_irq_in = 1; tif.meie_in = 1; tif.mie_in = 1;
    @(negedge clk);
    checks++; if (tif.trap_taken_out !== 1'b1) begin failures++; $display("FAIL exc_prio_trap got=%b exp=1", tif.trap_taken_out); end
    step(); idle();
    @(negedge clk);
    checks++; if ({tif.i_or_e_out, tif.cause_out} !== {1'b0, 4'd4}) begin failures++; $display("FAIL exc_prio_cause got=%0d/%0d exp=0/4", tif.i_or_e_out, tif.cause_out); end
    step();
  endtask

  task automatic test_irq_prio();
    idle(); tif.t_irq_in = 1; tif.mtie_in = 1; tif.s_irq_in = 1; tif.msie_in = 1; tif.mie_in = 1;
    @(negedge clk);
    checks++; if (tif.trap_taken_out !== 1'b1) begin failures++; $display("FAIL irq_trap got=%b exp=1", tif.trap_taken_out); end
    step(); idle();
    @(negedge clk);
    checks++; if ({tif.i_or_e_out, tif.cause_out} !== {1'b1, 4'd3}) begin failures++; $display("FAIL irq_cause got=%0d/%0d exp=1/3", tif.i_or_e_out, tif.cause_out); end
    step();
    tif.t_irq_in = 1; tif.mtie_in = 1; tif.s_irq_in = 1; tif.msie_in = 1; tif.mie_in = 0;
    @(negedge clk);
    checks++; if ({tif.trap_taken_out, tif.instret_inc_out} !== 2'b01)
      begin failures++; $display("FAIL irq_masked got=%b exp=01", {tif.trap_taken_out, tif.instret_inc_out}); end
    step();
    @(negedge clk);
    checks++; if ({tif.set_cause_out, tif.pc_src_out} !== 3'b011)
      begin failures++; $display("FAIL irq_masked_next got=%b exp=011", {tif.set_cause_out, tif.pc_src_out}); end
    step(); idle();
  endtask

  task automatic test_cause_table();
    logic [3:0] exp_c;
    logic       exp_i;
    for (int k = 0; k < 7; k++) begin
      idle(); exp_i = 0; exp_c = 0;
      case (k)
        0: begin tif.misaligned_instr_in = 1; exp_c = 0; end
        1: begin sys_instr(12'h000); exp_c = 11; end
        2: begin sys_instr(12'h001); exp_c = 3; end
        3: begin tif.misaligned_store_in = 1; exp_c = 6; end
        4: begin tif.e_irq_in = 1; tif.meie_in = 1; tif.s_irq_in = 1; tif.msie_in = 1; tif.mie_in = 1; exp_c = 11; exp_i = 1; end
        5: begin tif.t_irq_in = 1; tif.mtie_in = 1; tif.mie_in = 1; exp_c = 7; exp_i = 1; end
        default: begin tif.misaligned_instr_in = 1; tif.illegal_instr_in = 1; tif.misaligned_store_in = 1; exp_c = 0; end
      endcase
      step(); idle();
      @(negedge clk);
      checks++; if ({tif.set_cause_out, tif.i_or_e_out, tif.cause_out} !== {1'b1, exp_i, exp_c})
        begin failures++; $display("FAIL cause_tbl[%0d] got=%b/%0d/%0d exp=1/%0d/%0d", k, tif.set_cause_out, tif.i_or_e_out, tif.cause_out, exp_i, exp_c); end
      step();
    end
  endtask

  task automatic test_mret();
    idle(); sys_instr(12'h302);
    @(negedge clk);
    checks++; if ({tif.trap_taken_out, tif.instret_inc_out} !== 2'b01)
      begin failures++; $display("FAIL mret_retire got=%b exp=01", {tif.trap_taken_out, tif.instret_inc_out}); end
    step(); idle();
    @(negedge clk);
    checks++; if ({tif.mie_set_out, tif.flush_out, tif.pc_src_out, tif.instret_inc_out, tif.set_cause_out, tif.mie_clear_out} !== 7'b1101000)
      begin failures++; $display("FAIL mret_return got=%b exp=1101000", {tif.mie_set_out, tif.flush_out, tif.pc_src_out, tif.instret_inc_out, tif.set_cause_out, tif.mie_clear_out}); end
    step();
    @(negedge clk);
    checks++; if ({tif.mie_set_out, tif.pc_src_out, tif.instret_inc_out} !== 4'b0111)
      begin failures++; $display("FAIL mret_resume got=%b exp=0111", {tif.mie_set_out, tif.pc_src_out, tif.instret_inc_out}); end
    step();
  endtask

  task automatic test_exc_vs_mret();
    idle(); sys_instr(12'h302); tif.illegal_instr_in = 1;
    @(negedge clk);
    checks++; if (tif.trap_taken_out !== 1'b1) begin failures++; $display("FAIL exc_mret_trap got=%b exp=1", tif.trap_taken_out); end
    step(); idle();
    @(negedge clk);
    checks++; if ({tif.set_cause_out, tif.mie_set_out, tif.pc_src_out, tif.cause_out} !== {1'b1, 1'b0, 2'b10, 4'd2})
      begin failures++; $display("FAIL exc_mret_seq got=%b exp=10102", {tif.set_cause_out, tif.mie_set_out, tif.pc_src_out, tif.cause_out}); end
    step();
  endtask

  task automatic test_reset_mid_trap();
    idle(); tif.misaligned_store_in = 1;
    step(); idle();
    rst_n = 0; #1;
    checks++; if ({tif.set_cause_out, tif.set_epc_out, tif.mie_clear_out, tif.pc_src_out, tif.cause_out} !== 9'd0)
      begin failures++; $display("FAIL midtrap_reset got=%b exp=0", {tif.set_cause_out, tif.set_epc_out, tif.mie_clear_out, tif.pc_src_out, tif.cause_out}); end
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    checks++; if ({tif.set_cause_out, tif.mie_clear_out, tif.flush_out, tif.pc_src_out} !== 5'b00100)
      begin failures++; $display("FAIL midtrap_release got=%b exp=00100", {tif.set_cause_out, tif.mie_clear_out, tif.flush_out, tif.pc_src_out}); end
    step();
    @(negedge clk);
    checks++; if ({tif.set_cause_out, tif.pc_src_out, tif.instret_inc_out} !== 4'b0111)
      begin failures++; $display("FAIL midtrap_resume got=%b exp=0111", {tif.set_cause_out, tif.pc_src_out, tif.instret_inc_out}); end
    step();
  endtask

  task automatic test_wfi();
`ifdef MSRV32_WFI_EN
    for (int r = 0; r < 2; r++) begin
      idle(); tif.mie_in = logic'(r); sys_instr(12'h105);
      @(negedge clk);
      checks++; if ({tif.trap_taken_out, tif.instret_inc_out} !== 2'b01)
        begin failures++; $display("FAIL wfi_entry[%0d] got=%b exp=01", r, {tif.trap_taken_out, tif.instret_inc_out}); end
      step(); idle(); tif.mie_in = logic'(r);
      for (int w = 0; w < 5; w++) begin
        @(negedge clk);
        checks++; if ({tif.set_cause_out, tif.set_epc_out, tif.mie_clear_out, tif.mie_set_out, tif.instret_inc_out, tif.flush_out, tif.trap_taken_out, tif.pc_src_out} !== 9'b0000000_11)
          begin failures++; $display("FAIL wfi_wait[%0d.%0d] got=%b exp=000000011", r, w, {tif.set_cause_out, tif.set_epc_out, tif.mie_clear_out, tif.mie_set_out, tif.instret_inc_out, tif.flush_out, tif.trap_taken_out, tif.pc_src_out}); end
        step();
      end
      tif.e_irq_in = 1; tif.meie_in = 1;
      step(); idle();
      @(negedge clk);
      if (r == 0) begin
        checks++; if ({tif.set_cause_out, tif.pc_src_out, tif.instret_inc_out} !== 4'b0111)
          begin failures++; $display("FAIL wfi_wake_nomie got=%b exp=0111", {tif.set_cause_out, tif.pc_src_out, tif.instret_inc_out}); end
      end else begin
        checks++; if ({tif.set_cause_out, tif.pc_src_out, tif.i_or_e_out, tif.cause_out} !== {1'b1, 2'b10, 1'b1, 4'd11})
          begin failures++; $display("FAIL wfi_wake_mie got=%b exp=110111011", {tif.set_cause_out, tif.pc_src_out, tif.i_or_e_out, tif.cause_out}); end
      end
      step();
    end
`else
    idle(); sys_instr(12'h105);
    @(negedge clk);
    checks++; if ({tif.trap_taken_out, tif.instret_inc_out} !== 2'b01)
      begin failures++; $display("FAIL wfi_nop got=%b exp=01", {tif.trap_taken_out, tif.instret_inc_out}); end
    step(); idle();
    @(negedge clk);
    checks++; if ({tif.flush_out, tif.pc_src_out, tif.instret_inc_out} !== 4'b0111)
      begin failures++; $display("FAIL wfi_nop_next got=%b exp=0111", {tif.flush_out, tif.pc_src_out, tif.instret_inc_out}); end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_exc_prio();
    test_irq_prio();
    test_cause_table();
    test_mret();
    test_exc_vs_mret();
    test_reset_mid_trap();
    test_wfi();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
